// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous BRAM between core port C and loader port L.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (L over C).
module mem_arbiter #(
    parameter int MEM_WORDS    = 4096,
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [31:0]       c_addr,
    input  logic [31:0]       c_wdata,
    input  logic [3:0]        c_be,
    output logic [31:0]       c_rdata,
    output logic              c_resp,
    input  logic              l_read,
    input  logic              l_write,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    input  logic [3:0]        l_be,
    output logic [31:0]       l_rdata,
    output logic              l_resp,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,
    output logic [1:0]        gnt
);
    // state  | meaning
    // IDLE   | nothing in flight; arbitrate and latch the winner at the edge
    // ACCESS | bram_en / bram_we presented to the BRAM
    // WAIT   | READ_LATENCY cycles until bram_rdata is valid
    // RESP   | one-cycle resp pulse to the winner
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        c_req, l_req, grant, win_l;
    logic        own_l, op_wr, in_rng;
    logic [2:0]  wait_cnt;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_be;
    logic        sel_wr, sel_in_rng;
    logic        unused_addr_bits;
    logic [31:0] resp_word;

    assign c_req = c_read | c_write;
    assign l_req = l_read | l_write;
    assign grant = (state == IDLE) && (c_req || l_req);

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;  // 0 = C has the tie, 1 = L has the tie

    assign win_l = l_req && (!c_req || rr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (grant)
            rr_ptr <= ~win_l;
    end
`else
    assign win_l = l_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (c_req || l_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_addr  = win_l ? l_addr  : c_addr;
        sel_wdata = win_l ? l_wdata : c_wdata;
        sel_be    = win_l ? l_be    : c_be;
        sel_wr    = win_l ? l_write : c_write;
        gnt       = 2'b00;
        if (state != IDLE)
            gnt = own_l ? 2'b10 : 2'b01;
    end

    assign sel_in_rng       = sel_addr[31:2] < 30'(MEM_WORDS);
    assign unused_addr_bits = ^sel_addr[1:0];
    // Writes and out-of-range accesses return zero instead of whatever the BRAM drives.
    assign resp_word        = (op_wr || !in_rng) ? 32'h0 : bram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_l      <= 1'b0;
            op_wr      <= 1'b0;
            in_rng     <= 1'b0;
            wait_cnt   <= '0;
            bram_en    <= 1'b0;
            bram_we    <= 4'h0;
            bram_addr  <= '0;
            bram_wdata <= 32'h0;
            c_resp     <= 1'b0;
            l_resp     <= 1'b0;
            c_rdata    <= 32'h0;
            l_rdata    <= 32'h0;
        end else begin
            c_resp  <= 1'b0;
            l_resp  <= 1'b0;
            bram_en <= 1'b0;
            bram_we <= 4'h0;
            if (grant) begin
                own_l      <= win_l;
                op_wr      <= sel_wr;
                in_rng     <= sel_in_rng;
                bram_en    <= sel_in_rng;
                bram_we    <= (sel_wr && sel_in_rng) ? sel_be : 4'h0;
                bram_addr  <= sel_addr[ADDR_W+1:2];
                bram_wdata <= sel_wdata;
            end
            if (state == ACCESS)
                wait_cnt <= 3'(READ_LATENCY - 1);
            else if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 3'd1;
            if (state == WAIT && wait_cnt == '0) begin
                if (own_l) begin
                    l_resp  <= 1'b1;
                    l_rdata <= resp_word;
                end else begin
                    c_resp  <= 1'b1;
                    c_rdata <= resp_word;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (READ_LATENCY 1 and 3 instances).
// Honours MEM_ARB_RR_EN the same way as the design.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          exp_ptr = 0;

    logic        c_read, c_write, l_read, l_write;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata, c_rdata, l_rdata;
    logic [3:0]  c_be, l_be, bram_we;
    logic        c_resp, l_resp, bram_en;
    logic [11:0] bram_addr;
    logic [31:0] bram_wdata, bram_rdata;
    logic [1:0]  gnt;

    logic        x_c_read, x_c_write, x_l_read, x_l_write;
    logic [31:0] x_c_addr, x_c_wdata, x_l_addr, x_l_wdata, x_c_rdata, x_l_rdata;
    logic [3:0]  x_c_be, x_l_be, x_bram_we;
    logic        x_c_resp, x_l_resp, x_bram_en;
    logic [3:0]  x_bram_addr;
    logic [31:0] x_bram_wdata, x_bram_rdata;
    logic [1:0]  x_gnt;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.MEM_WORDS(4096), .ADDR_W(12), .READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_rdata(c_rdata), .c_resp(c_resp),
        .l_read(l_read), .l_write(l_write), .l_addr(l_addr), .l_wdata(l_wdata), .l_be(l_be),
        .l_rdata(l_rdata), .l_resp(l_resp),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata), .gnt(gnt)
    );

    mem_arbiter #(.MEM_WORDS(16), .ADDR_W(4), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .c_read(x_c_read), .c_write(x_c_write), .c_addr(x_c_addr), .c_wdata(x_c_wdata), .c_be(x_c_be),
        .c_rdata(x_c_rdata), .c_resp(x_c_resp),
        .l_read(x_l_read), .l_write(x_l_write), .l_addr(x_l_addr), .l_wdata(x_l_wdata), .l_be(x_l_be),
        .l_rdata(x_l_rdata), .l_resp(x_l_resp),
        .bram_en(x_bram_en), .bram_we(x_bram_we), .bram_addr(x_bram_addr), .bram_wdata(x_bram_wdata),
        .bram_rdata(x_bram_rdata), .gnt(x_gnt)
    );

    // BRAM models: latency 1, and a 3-stage pipeline that poisons idle slots
    logic [31:0] mem1 [0:4095];
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem1[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            rd1 <= mem1[bram_addr];
        end else begin
            rd1 <= 32'hBAD0BAD0;
        end
    end
    assign bram_rdata = rd1;

    logic [31:0] mem3 [0:15];
    logic [31:0] p3 [0:2];
    always @(posedge clk) begin
        if (x_bram_en)
            for (int b = 0; b < 4; b++)
                if (x_bram_we[b]) mem3[x_bram_addr][8*b +: 8] <= x_bram_wdata[8*b +: 8];
        p3[0] <= x_bram_en ? mem3[x_bram_addr] : 32'hBAD0BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign x_bram_rdata = p3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (c_resp || l_resp) got = 1'b1;
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (got) begin
                chk({tag, "_resp"}, {30'd0, l_resp, c_resp}, (e.port != 0) ? 32'd2 : 32'd1);
                chk({tag, "_gnt"}, {30'd0, gnt}, (e.port != 0) ? 32'd2 : 32'd1);
                chk({tag, "_rdata"}, (e.port != 0) ? l_rdata : c_rdata, e.rdata);
                chk({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    task automatic do_access(input int port, input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be,
                             input logic [31:0] exp_rd, input string tag);
        exp_t e;
        bit   inr;
        e.port  = port;
        e.rdata = exp_rd;
        e.cyc   = cyc + 3;
        sb.push_back(e);
        exp_ptr = (port != 0) ? 0 : 1;
        inr     = (a < 32'h4000);
        if (port == 0) begin
            c_read = rd; c_write = wr; c_addr = a; c_wdata = wd; c_be = be;
        end else begin
            l_read = rd; l_write = wr; l_addr = a; l_wdata = wd; l_be = be;
        end
        @(negedge clk);
        chk({tag, "_acc_gnt"}, {30'd0, gnt}, (port != 0) ? 32'd2 : 32'd1);
        chk({tag, "_acc_en"}, {31'd0, bram_en}, {31'd0, inr});
        chk({tag, "_acc_we"}, {28'd0, bram_we}, (wr && inr) ? {28'd0, be} : 32'd0);
        if (inr) chk({tag, "_acc_addr"}, {20'd0, bram_addr}, {20'd0, a[13:2]});
        if (wr)  chk({tag, "_acc_wdata"}, bram_wdata, wd);
        wait_resp(tag);
        c_read = 0; c_write = 0; l_read = 0; l_write = 0;
        @(negedge clk);
    endtask

    task automatic d3_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        exp_t e;
        bit   got;
        got     = 1'b0;
        e.port  = 0;
        e.rdata = exp_rd;
        e.cyc   = cyc + 5;
        sb.push_back(e);
        x_c_read = rd; x_c_write = wr; x_c_addr = a; x_c_wdata = wd; x_c_be = 4'hF;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (x_c_resp) got = 1'b1;
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
        e = sb.pop_front();
        if (got) begin
            chk({tag, "_rdata"}, x_c_rdata, e.rdata);
            chk({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
        end
        x_c_read = 0; x_c_write = 0;
        @(negedge clk);
    endtask

    initial begin
        int w;
        int t_next;
        exp_t e;
        rst_n = 1'b0;
        c_read = 0; c_write = 0; c_addr = 0; c_wdata = 0; c_be = 0;
        l_read = 0; l_write = 0; l_addr = 0; l_wdata = 0; l_be = 0;
        x_c_read = 0; x_c_write = 0; x_c_addr = 0; x_c_wdata = 0; x_c_be = 0;
        x_l_read = 0; x_l_write = 0; x_l_addr = 0; x_l_wdata = 0; x_l_be = 0;
        repeat (2) @(negedge clk);

        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_resp", {30'd0, l_resp, c_resp}, 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_l_rdata", l_rdata, 32'd0);
        chk("rst_bram_en", {31'd0, bram_en}, 32'd0);
        chk("rst_bram_we", {28'd0, bram_we}, 32'd0);
        chk("rst_bram_addr", {20'd0, bram_addr}, 32'd0);
        chk("rst_bram_wdata", bram_wdata, 32'd0);
        chk("rst_x_resp", {31'd0, x_c_resp}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_access(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, "c_wr_full");
        do_access(0, 1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, "c_rd_full");
        do_access(0, 0, 1, 32'h10, 32'h0000AA00, 4'h2, 32'h0, "c_wr_byte1");
        do_access(0, 1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADAAEF, "c_rd_byte1");
        do_access(0, 1, 1, 32'h20, 32'h12345678, 4'hF, 32'h0, "c_rdwr_both");
        do_access(0, 1, 0, 32'h20, 32'h0, 4'hF, 32'h12345678, "c_rd_both");
        do_access(1, 0, 1, 32'h40, 32'hA5A55A5A, 4'hF, 32'h0, "l_wr");
        do_access(1, 1, 0, 32'h40, 32'h0, 4'hF, 32'hA5A55A5A, "l_rd");
        do_access(0, 1, 0, 32'h4000, 32'h0, 4'hF, 32'h0, "c_rd_oor");
        do_access(0, 0, 1, 32'h4010, 32'hFFFFFFFF, 4'hF, 32'h0, "c_wr_oor");
        do_access(0, 1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADAAEF, "c_rd_after_oor");

        d3_access(0, 1, 32'h10, 32'hCAFEF00D, 32'h0, "rl3_wr");
        d3_access(1, 0, 32'h10, 32'h0, 32'hCAFEF00D, "rl3_rd");

        // both ports hammer reads; winner sequence depends on the arbitration build
        c_read = 1; c_addr = 32'h10; c_be = 4'hF;
        l_read = 1; l_addr = 32'h40; l_be = 4'hF;
        t_next = cyc + 3;
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
            w = exp_ptr;
            exp_ptr = (w != 0) ? 0 : 1;
`else
            w = 1;
`endif
            e.port  = w;
            e.rdata = (w != 0) ? 32'hA5A55A5A : 32'hDEADAAEF;
            e.cyc   = t_next;
            sb.push_back(e);
            wait_resp("contend");
            t_next = cyc + 4;
        end
        c_read = 0; l_read = 0;
        @(negedge clk);

        // reset during WAIT, request held across it
        c_read = 1; c_addr = 32'h10; c_be = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_gnt", {30'd0, gnt}, 32'd0);
        chk("midrst_resp", {30'd0, l_resp, c_resp}, 32'd0);
        chk("midrst_bram_en", {31'd0, bram_en}, 32'd0);
        chk("midrst_c_rdata", c_rdata, 32'd0);
        rst_n = 1'b1;
        exp_ptr = 1;
        e.port  = 0;
        e.rdata = 32'hDEADAAEF;
        e.cyc   = cyc + 3;
        sb.push_back(e);
        wait_resp("after_rst");
        c_read = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
